t_vals_tx: RTL and testbench

T_VALS_TX -- requirements
Module: t_vals_tx

---
 rtl/t_vals_tx.sv | 207 ++++++++++++++++++++
 tb/tb_t_vals_tx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/t_vals_tx.sv
// t_vals_tx: accumulates FORMANTS segment sums per frame into cumulative T values,
// then strobes them to the phi stage and handshakes on input_completed.
// Optional feature macro: TVAL_SATURATE_EN (signed clamping of the accumulators
// plus a sticky sat_flag output); default build wraps modulo 2^BIT_WIDTH.
module t_vals_tx #(
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned FORMANTS  = 5
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 seg_valid,
    output logic                 seg_ready,
    input  logic [BIT_WIDTH-1:0] seg_sum_0,
    input  logic [BIT_WIDTH-1:0] seg_sum_1,
    input  logic [BIT_WIDTH-1:0] seg_sum_2,
    output logic                 input_start,
    output logic                 input_valid,
    output logic [BIT_WIDTH-1:0] T_vals_0,
    output logic [BIT_WIDTH-1:0] T_vals_1,
    output logic [BIT_WIDTH-1:0] T_vals_2,
    input  logic                 input_completed,
    output logic                 busy
`ifdef TVAL_SATURATE_EN
    ,
    output logic                 sat_flag
`endif
);

    localparam int unsigned K_W = (FORMANTS > 1) ? $clog2(FORMANTS) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(FORMANTS - 1);

    typedef enum logic [2:0] {
        COLLECT   = 3'd0,
        START     = 3'd1,
        SEND      = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_DONE = 3'd4
    } state_e;

    state_e state_q, state_d;
    logic [K_W-1:0] k_q, k_d;
    logic [BIT_WIDTH-1:0] acc0_q, acc0_d, acc1_q, acc1_d, acc2_q, acc2_d;
    logic [FORMANTS-1:0][BIT_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d, buf2_q, buf2_d;
    logic [BIT_WIDTH-1:0] new0, new1, new2;
    logic seg_ready_d, busy_d, input_start_d, input_valid_d;
    logic [BIT_WIDTH-1:0] t0_d, t1_d, t2_d;
    logic accept;

`ifdef TVAL_SATURATE_EN
    localparam logic [BIT_WIDTH-1:0] S_MAX = {1'b0, {(BIT_WIDTH-1){1'b1}}};
    localparam logic [BIT_WIDTH-1:0] S_MIN = {1'b1, {(BIT_WIDTH-1){1'b0}}};

    logic sat_q, sat_d;
    logic [2:0] sat_hit;

    // Signed add clamped to the two's complement limits; MSB of result flags a clamp.
    function automatic logic [BIT_WIDTH:0] sat_add(input logic [BIT_WIDTH-1:0] a,
                                                   input logic [BIT_WIDTH-1:0] b);
        logic [BIT_WIDTH-1:0] s;
        s = a + b;
        if ((a[BIT_WIDTH-1] == b[BIT_WIDTH-1]) && (s[BIT_WIDTH-1] != a[BIT_WIDTH-1])) begin
            return {1'b1, (a[BIT_WIDTH-1] ? S_MIN : S_MAX)};
        end
        return {1'b0, s};
    endfunction
`endif

    // Candidate accumulator values for an accept this cycle.
    always_comb begin
`ifdef TVAL_SATURATE_EN
        {sat_hit[0], new0} = sat_add(acc0_q, seg_sum_0);
        {sat_hit[1], new1} = sat_add(acc1_q, seg_sum_1);
        {sat_hit[2], new2} = sat_add(acc2_q, seg_sum_2);
`else
        new0 = acc0_q + seg_sum_0;
        new1 = acc1_q + seg_sum_1;
        new2 = acc2_q + seg_sum_2;
`endif
    end

    // Next-state, datapath and registered-output decode (outputs follow the next state).
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc0_d  = acc0_q;
        acc1_d  = acc1_q;
        acc2_d  = acc2_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        buf2_d  = buf2_q;
`ifdef TVAL_SATURATE_EN
        sat_d   = sat_q;
`endif
        accept  = seg_valid && seg_ready;

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    acc0_d      = new0;
                    acc1_d      = new1;
                    acc2_d      = new2;
                    buf0_d[k_q] = new0;
                    buf1_d[k_q] = new1;
                    buf2_d[k_q] = new2;
`ifdef TVAL_SATURATE_EN
                    sat_d       = sat_q | (|sat_hit);
`endif
                    if (k_q == K_LAST) begin
                        state_d = START;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + K_W'(1);
                    end
                end
            end
            START: begin
                state_d = SEND;
                k_d     = '0;
            end
            SEND: begin
                if (k_q == K_LAST) begin
                    state_d = WAIT_ACK;
                    k_d     = '0;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            WAIT_ACK: begin
                if (input_completed) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!input_completed) begin
                    state_d = COLLECT;
                    k_d     = '0;
                    acc0_d  = '0;
                    acc1_d  = '0;
                    acc2_d  = '0;
`ifdef TVAL_SATURATE_EN
                    sat_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d = COLLECT;
                k_d     = '0;
            end
        endcase

        seg_ready_d   = (state_d == COLLECT);
        busy_d        = (state_d != COLLECT);
        input_start_d = (state_d == START);
        input_valid_d = (state_d == SEND);
        t0_d          = input_valid_d ? buf0_q[k_d] : '0;
        t1_d          = input_valid_d ? buf1_q[k_d] : '0;
        t2_d          = input_valid_d ? buf2_q[k_d] : '0;
    end

    // State, datapath and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= COLLECT;
            k_q         <= '0;
            acc0_q      <= '0;
            acc1_q      <= '0;
            acc2_q      <= '0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            buf2_q      <= '0;
            seg_ready   <= 1'b1;
            busy        <= 1'b0;
            input_start <= 1'b0;
            input_valid <= 1'b0;
            T_vals_0    <= '0;
            T_vals_1    <= '0;
            T_vals_2    <= '0;
`ifdef TVAL_SATURATE_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            acc0_q      <= acc0_d;
            acc1_q      <= acc1_d;
            acc2_q      <= acc2_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            buf2_q      <= buf2_d;
            seg_ready   <= seg_ready_d;
            busy        <= busy_d;
            input_start <= input_start_d;
            input_valid <= input_valid_d;
            T_vals_0    <= t0_d;
            T_vals_1    <= t1_d;
            T_vals_2    <= t2_d;
`ifdef TVAL_SATURATE_EN
            sat_q       <= sat_d;
`endif
        end
    end

`ifdef TVAL_SATURATE_EN
    assign sat_flag = sat_q;
`endif

endmodule

// File: tb/tb_t_vals_tx.sv
// Bench for t_vals_tx: directed frames plus randomized frames checked against a
// frame-level model of cumulative T values and the handshake timeline.
module tb_t_vals_tx;

    localparam int BW = 32;
    localparam int F  = 5;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          seg_valid;
    logic          seg_ready;
    logic [BW-1:0] seg_sum_0, seg_sum_1, seg_sum_2;
    logic          input_start, input_valid;
    logic [BW-1:0] T_vals_0, T_vals_1, T_vals_2;
    logic          input_completed;
    logic          busy;
`ifdef TVAL_SATURATE_EN
    logic          sat_flag;
`endif

    t_vals_tx #(.BIT_WIDTH(BW), .FORMANTS(F)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .seg_valid       (seg_valid),
        .seg_ready       (seg_ready),
        .seg_sum_0       (seg_sum_0),
        .seg_sum_1       (seg_sum_1),
        .seg_sum_2       (seg_sum_2),
        .input_start     (input_start),
        .input_valid     (input_valid),
        .T_vals_0        (T_vals_0),
        .T_vals_1        (T_vals_1),
        .T_vals_2        (T_vals_2),
        .input_completed (input_completed),
        .busy            (busy)
`ifdef TVAL_SATURATE_EN
        ,
        .sat_flag        (sat_flag)
`endif
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Pending segment left on the bus while the block is busy.
    bit            pend = 1'b0;
    logic [BW-1:0] p0, p1, p2;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference accumulation: signed arithmetic, wrapped or clamped to BW bits.
    task automatic m_add(input logic [BW-1:0] a, input logic [BW-1:0] b,
                         output logic [BW-1:0] r, inout bit sat);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
`ifdef TVAL_SATURATE_EN
        if (s > 64'sd2147483647) begin
            s = 64'sd2147483647; sat = 1'b1;
        end else if (s < -64'sd2147483648) begin
            s = -64'sd2147483648; sat = 1'b1;
        end
`endif
        r = s[BW-1:0];
    endtask

    task automatic gen_seg(input int mode, input int k,
                           output logic [BW-1:0] s0, output logic [BW-1:0] s1, output logic [BW-1:0] s2);
        case (mode)
            1: begin s0 = BW'(10); s1 = BW'(20); s2 = BW'(30); end
            2: begin s0 = BW'(-5); s1 = BW'(0);  s2 = BW'(7);  end
            3: begin
                s0 = (k < 2) ? 32'h7FFFFFF0 : BW'($urandom_range(0, 100));
                s1 = BW'($urandom_range(0, 100));
                s2 = BW'($urandom_range(0, 100));
            end
            default: begin s0 = $urandom; s1 = $urandom; s2 = $urandom; end
        endcase
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // One frame: collect F segments (gap idle cycles between), check the strobes,
    // then the completion handshake. abort_at >= 0 resets during that strobe.
    task automatic run_frame(input int mode, input int gap, input bit hold, input int abort_at);
        logic [BW-1:0] s0, s1, s2;
        logic [BW-1:0] a0, a1, a2;
        logic [BW-1:0] c0 [F];
        logic [BW-1:0] c1 [F];
        logic [BW-1:0] c2 [F];
        bit sat_exp;
        int wait_cyc;
        a0 = '0; a1 = '0; a2 = '0; sat_exp = 1'b0;
        for (int k = 0; k < F; k++) begin
            if (k == 0 && pend) begin
                s0 = p0; s1 = p1; s2 = p2; pend = 1'b0;
            end else begin
                gen_seg(mode, k, s0, s1, s2);
                seg_valid = 1'b1; seg_sum_0 = s0; seg_sum_1 = s1; seg_sum_2 = s2;
            end
            m_add(a0, s0, a0, sat_exp);
            m_add(a1, s1, a1, sat_exp);
            m_add(a2, s2, a2, sat_exp);
            c0[k] = a0; c1[k] = a1; c2[k] = a2;
            tick();
            seg_valid = 1'b0;
            if (k < F - 1) begin
                chk("collect_ready", BW'(seg_ready), BW'(1));
                chk("collect_no_start", BW'(input_start), BW'(0));
                chk("collect_no_valid", BW'(input_valid), BW'(0));
                for (int g = 0; g < gap; g++) begin
                    input_completed = 1'($urandom_range(0, 1));
                    tick();
                    chk("gap_no_valid", BW'(input_valid), BW'(0));
                    chk("gap_ready", BW'(seg_ready), BW'(1));
                    chk("gap_busy", BW'(busy), BW'(0));
                end
                input_completed = 1'b0;
            end
        end
        if (hold) begin
            gen_seg(0, 0, p0, p1, p2);
            pend = 1'b1;
            seg_valid = 1'b1; seg_sum_0 = p0; seg_sum_1 = p1; seg_sum_2 = p2;
        end
        chk("start_pulse", BW'(input_start), BW'(1));
        chk("start_no_valid", BW'(input_valid), BW'(0));
        chk("start_not_ready", BW'(seg_ready), BW'(0));
        chk("start_busy", BW'(busy), BW'(1));
        chk("start_t0_zero", T_vals_0, BW'(0));
        for (int j = 0; j < F; j++) begin
            tick();
            chk("send_valid", BW'(input_valid), BW'(1));
            chk("send_no_start", BW'(input_start), BW'(0));
            chk("send_not_ready", BW'(seg_ready), BW'(0));
            chk("send_t0", T_vals_0, c0[j]);
            chk("send_t1", T_vals_1, c1[j]);
            chk("send_t2", T_vals_2, c2[j]);
`ifdef TVAL_SATURATE_EN
            chk("send_sat_flag", BW'(sat_flag), BW'(sat_exp));
            if (mode == 3 && j == 1) chk("sat_entry1", T_vals_0, 32'h7FFFFFFF);
`else
            if (mode == 3 && j == 1) chk("wrap_entry1", T_vals_0, 32'hFFFFFFE0);
`endif
            if (j == abort_at) begin
                #2;
                rst_n_in = 1'b0;
                #1;
                chk("abort_valid", BW'(input_valid), BW'(0));
                chk("abort_start", BW'(input_start), BW'(0));
                chk("abort_ready", BW'(seg_ready), BW'(1));
                chk("abort_busy", BW'(busy), BW'(0));
                chk("abort_t0", T_vals_0, BW'(0));
                chk("abort_t2", T_vals_2, BW'(0));
                @(negedge clk_in);
                rst_n_in = 1'b1;
                tick();
                chk("post_abort_valid", BW'(input_valid), BW'(0));
                chk("post_abort_ready", BW'(seg_ready), BW'(1));
                return;
            end
        end
        wait_cyc = hold ? 5 : $urandom_range(1, 4);
        for (int w = 0; w < wait_cyc; w++) begin
            tick();
            chk("ack_no_valid", BW'(input_valid), BW'(0));
            chk("ack_t1_zero", T_vals_1, BW'(0));
            chk("ack_not_ready", BW'(seg_ready), BW'(0));
            chk("ack_busy", BW'(busy), BW'(1));
        end
        input_completed = 1'b1;
        for (int w = 0; w < (hold ? 10 : $urandom_range(1, 3)); w++) begin
            tick();
            chk("done_not_ready", BW'(seg_ready), BW'(0));
            chk("done_busy", BW'(busy), BW'(1));
            chk("done_no_valid", BW'(input_valid), BW'(0));
        end
        input_completed = 1'b0;
        tick();
        chk("return_ready", BW'(seg_ready), BW'(1));
        chk("return_busy", BW'(busy), BW'(0));
`ifdef TVAL_SATURATE_EN
        chk("return_sat_clear", BW'(sat_flag), BW'(0));
`endif
    endtask

    initial begin
        rst_n_in = 1'b0;
        seg_valid = 1'b0;
        input_completed = 1'b0;
        seg_sum_0 = '0; seg_sum_1 = '0; seg_sum_2 = '0;
        #12;
        chk("rst_ready", BW'(seg_ready), BW'(1));
        chk("rst_start", BW'(input_start), BW'(0));
        chk("rst_valid", BW'(input_valid), BW'(0));
        chk("rst_busy", BW'(busy), BW'(0));
        chk("rst_t0", T_vals_0, BW'(0));
        chk("rst_t1", T_vals_1, BW'(0));
        chk("rst_t2", T_vals_2, BW'(0));
`ifdef TVAL_SATURATE_EN
        chk("rst_sat", BW'(sat_flag), BW'(0));
`endif
        @(negedge clk_in);
        rst_n_in = 1'b1;
        tick();
        chk("idle_ready", BW'(seg_ready), BW'(1));

        run_frame(1, 0, 1'b0, -1);
        run_frame(2, 3, 1'b0, -1);
        run_frame(0, 1, 1'b1, -1);
        run_frame(0, 0, 1'b0, -1);
        run_frame(3, 0, 1'b0, -1);
        run_frame(0, 2, 1'b0, 2);
        run_frame(1, 0, 1'b0, -1);
        for (int n = 0; n < 6; n++) begin
            run_frame(0, $urandom_range(0, 3), (n < 5) ? 1'($urandom_range(0, 1)) : 1'b0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
